// File: rtl/ram_sync_read_sdp_if.sv
// Bus bundle for ram_sync_read_sdp: write port, read port and sweep status.
// master drives accesses; slave is the RAM.
interface ram_sync_read_sdp_if #(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 32
);
  localparam int NBYTES = DWIDTH / 8;

  logic              wr_en;
  logic [AWIDTH-1:0] wr_addr;
  logic [NBYTES-1:0] wr_be;
  logic [DWIDTH-1:0] wr_data;
  logic              rd_en;
  logic [AWIDTH-1:0] rd_addr;
  logic [DWIDTH-1:0] rd_data;
  logic              rd_valid;
  logic              init_busy;

  modport master (
    output wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
    input  rd_data, rd_valid, init_busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
    output rd_data, rd_valid, init_busy
  );
endinterface

// File: rtl/ram_sync_read_sdp.sv
// Simple-dual-port RAM: byte-enabled write port, synchronous read port with
// 1- or 2-cycle latency, selectable collision policy and post-reset clear sweep.
module ram_sync_read_sdp #(
  parameter int              AWIDTH        = 3,
  parameter int              DWIDTH        = 32,
  parameter int              OUT_REG       = 0,
  parameter int              RW_MODE       = 0,
  parameter int              INIT_ON_RESET = 1,
  parameter logic [DWIDTH-1:0] INIT_VALUE  = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  ram_sync_read_sdp_if.slave    bus
);
  localparam int DEPTH  = 2 ** AWIDTH;
  localparam int NBYTES = DWIDTH / 8;

  typedef enum logic {ST_INIT, ST_RUN} state_t;
  localparam state_t RESET_STATE = (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;

  state_t            state_reg, state_next;
  logic [AWIDTH-1:0] cnt_reg, cnt_next;
  logic              run;

  logic [DWIDTH-1:0] mem [DEPTH];

  logic              mem_we;
  logic [AWIDTH-1:0] mem_waddr;
  logic [NBYTES-1:0] mem_wbe;
  logic [DWIDTH-1:0] mem_wdata;
  logic [DWIDTH-1:0] rd_word;

  logic [DWIDTH-1:0] rd1_data_reg;
  logic              rd1_valid_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= RESET_STATE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_INIT: begin
        cnt_next = cnt_reg + AWIDTH'(1);
        if (cnt_reg == AWIDTH'(DEPTH - 1)) begin
          state_next = ST_RUN;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  assign run           = (state_reg == ST_RUN);
  assign bus.init_busy = ~run;

  // The sweep borrows the write port; user traffic is ignored until RUN.
  assign mem_we    = ~reset & (~run | bus.wr_en);
  assign mem_waddr = run ? bus.wr_addr : cnt_reg;
  assign mem_wbe   = run ? bus.wr_be   : '1;
  assign mem_wdata = run ? bus.wr_data : INIT_VALUE;

  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (mem_wbe[b]) mem[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  // Write-first forwards enabled bytes of a same-address write into the read.
  generate
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_fwd
      logic fwd;
      assign fwd = (RW_MODE != 0) && run && bus.wr_en && bus.wr_be[gi] &&
                   (bus.wr_addr == bus.rd_addr);
      assign rd_word[8*gi +: 8] = fwd ? bus.wr_data[8*gi +: 8]
                                      : mem[bus.rd_addr][8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd1_data_reg  <= '0;
      rd1_valid_reg <= 1'b0;
    end else if (!run) begin
      rd1_data_reg  <= '0;
      rd1_valid_reg <= 1'b0;
    end else begin
      rd1_valid_reg <= bus.rd_en;
      if (bus.rd_en) rd1_data_reg <= rd_word;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DWIDTH-1:0] rd2_data_reg;
      logic              rd2_valid_reg;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          rd2_data_reg  <= '0;
          rd2_valid_reg <= 1'b0;
        end else if (!run) begin
          rd2_data_reg  <= '0;
          rd2_valid_reg <= 1'b0;
        end else begin
          rd2_valid_reg <= rd1_valid_reg;
          if (rd1_valid_reg) rd2_data_reg <= rd1_data_reg;
        end
      end

      assign bus.rd_data  = rd2_data_reg;
      assign bus.rd_valid = rd2_valid_reg;
    end else begin : g_no_out_reg
      assign bus.rd_data  = rd1_data_reg;
      assign bus.rd_valid = rd1_valid_reg;
    end
  endgenerate
endmodule

// File: tb/tb_ram_sync_read_sdp.sv
// Scoreboard bench: two RAM instances (read-first/latency 1, write-first/latency 2)
// driven by identical traffic and checked against an array model.
module tb_ram_sync_read_sdp;
  localparam logic [31:0] IV = 32'hA5A5A5A5;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  ram_sync_read_sdp_if #(.AWIDTH(3), .DWIDTH(32)) bus0 ();
  ram_sync_read_sdp_if #(.AWIDTH(3), .DWIDTH(32)) bus1 ();

  ram_sync_read_sdp #(.AWIDTH(3), .DWIDTH(32), .OUT_REG(0), .RW_MODE(0),
                      .INIT_ON_RESET(1), .INIT_VALUE(IV))
    dut0 (.clock(clock), .reset(reset), .bus(bus0));

  ram_sync_read_sdp #(.AWIDTH(3), .DWIDTH(32), .OUT_REG(1), .RW_MODE(1),
                      .INIT_ON_RESET(1), .INIT_VALUE(IV))
    dut1 (.clock(clock), .reset(reset), .bus(bus1));

  logic [31:0] rd_data_v [2];
  logic        rd_valid_v[2];
  logic        busy_v    [2];
  assign rd_data_v[0]  = bus0.rd_data;
  assign rd_data_v[1]  = bus1.rd_data;
  assign rd_valid_v[0] = bus0.rd_valid;
  assign rd_valid_v[1] = bus1.rd_valid;
  assign busy_v[0]     = bus0.init_busy;
  assign busy_v[1]     = bus1.init_busy;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        exp_q[2][$];
  logic [31:0] last_data[2];
  logic [31:0] model_mem[8];
  int          lat[2] = '{1, 2};

  function automatic void chk(string name, int d, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s dut%0d: got %h, expected %h (cycle %0d)", name, d, act, exp, cyc);
    end
  endfunction

  function automatic void flush();
    for (int d = 0; d < 2; d++) begin
      exp_q[d].delete();
      last_data[d] = '0;
    end
  endfunction

  task automatic drive(logic we, logic [2:0] wa, logic [3:0] be, logic [31:0] wd,
                       logic re, logic [2:0] ra);
    bus0.wr_en = we; bus0.wr_addr = wa; bus0.wr_be = be; bus0.wr_data = wd;
    bus0.rd_en = re; bus0.rd_addr = ra;
    bus1.wr_en = we; bus1.wr_addr = wa; bus1.wr_be = be; bus1.wr_data = wd;
    bus1.rd_en = re; bus1.rd_addr = ra;
  endtask

  // One access cycle: drive, predict from the model, then apply the write.
  task automatic op(logic we, logic [2:0] wa, logic [3:0] be, logic [31:0] wd,
                    logic re, logic [2:0] ra,
                    bit use_exp = 0, logic [31:0] e0 = '0, logic [31:0] e1 = '0);
    logic [31:0] old_w, new_w;
    @(negedge clock); #2;
    drive(we, wa, be, wd, re, ra);
    old_w = model_mem[wa];
    new_w = old_w;
    for (int b = 0; b < 4; b++)
      if (be[b]) new_w[8*b +: 8] = wd[8*b +: 8];
    if (re) begin
      exp_t e;
      logic [31:0] rf, wf;
      rf = model_mem[ra];
      wf = (we && wa == ra) ? new_w : model_mem[ra];
      if (use_exp) begin rf = e0; wf = e1; end
      e.data = rf; e.due = cyc + lat[0]; exp_q[0].push_back(e);
      e.data = wf; e.due = cyc + lat[1]; exp_q[1].push_back(e);
    end
    if (we) model_mem[wa] = new_w;
  endtask

  task automatic idle(int n);
    repeat (n) op(1'b0, 3'd0, 4'd0, 32'd0, 1'b0, 3'd0);
  endtask

  task automatic assert_reset_and_check(string tag);
    @(negedge clock); #2;
    drive(1'b0, 3'd0, 4'd0, 32'd0, 1'b0, 3'd0);
    reset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_rd_valid"}, d, 32'(rd_valid_v[d]), 32'd0);
      chk({tag, "_rd_data"}, d, rd_data_v[d], 32'd0);
      chk({tag, "_init_busy"}, d, 32'(busy_v[d]), 32'd1);
    end
    flush();
  endtask

  // Reset, optionally abort the sweep after abort_after cycles, then time the full sweep
  // while hammering the ports with traffic that must be ignored.
  task automatic reset_and_sweep(int abort_after);
    int n[2];
    assert_reset_and_check("reset");
    @(negedge clock); #2;
    reset = 1'b0;
    if (abort_after > 0) begin
      repeat (abort_after) begin
        drive(1'b1, 3'd0, 4'hF, 32'hCAFEF00D, 1'b1, 3'd0);
        @(negedge clock); #2;
      end
      assert_reset_and_check("mid_sweep");
      @(negedge clock); #2;
      reset = 1'b0;
    end
    n = '{0, 0};
    for (int i = 0; i < 40; i++) begin
      if (!busy_v[0] && !busy_v[1]) break;
      for (int d = 0; d < 2; d++) if (busy_v[d]) n[d]++;
      drive(1'b1, 3'd0, 4'hF, 32'hCAFEF00D, 1'b1, 3'd0);
      @(negedge clock); #2;
    end
    drive(1'b0, 3'd0, 4'd0, 32'd0, 1'b0, 3'd0);
    for (int d = 0; d < 2; d++) chk("sweep_len", d, n[d], 32'd8);
    for (int a = 0; a < 8; a++) model_mem[a] = IV;
  endtask

  // Monitor: pops on rd_valid, checks data and arrival cycle, and data hold otherwise.
  always @(negedge clock) begin
    if (!reset) begin
      for (int d = 0; d < 2; d++) begin
        if (rd_valid_v[d]) begin
          if (exp_q[d].size() == 0) begin
            chk("unexpected_rd_valid", d, 32'd1, 32'd0);
          end else begin
            exp_t e;
            e = exp_q[d].pop_front();
            $display("[TB] dut%0d cycle %0d rd_data %h expected %h", d, cyc, rd_data_v[d], e.data);
            chk("rd_data", d, rd_data_v[d], e.data);
            chk("latency", d, cyc, e.due);
          end
          last_data[d] = rd_data_v[d];
        end else begin
          chk("rd_data_hold", d, rd_data_v[d], last_data[d]);
          if (exp_q[d].size() != 0 && exp_q[d][0].due < cyc) begin
            exp_t e;
            e = exp_q[d].pop_front();
            chk("missing_rd_valid", d, 32'd0, 32'd1);
          end
        end
      end
    end
  end

  initial begin
    drive(1'b0, 3'd0, 4'd0, 32'd0, 1'b0, 3'd0);
    flush();
    #1 reset = 1'b1;

    // Sweep length, ignored traffic, and contents afterwards.
    reset_and_sweep(0);
    for (int a = 0; a < 8; a++) op(1'b0, 3'd0, 4'd0, 32'd0, 1'b1, 3'(a), 1, IV, IV);
    idle(3);

    // Byte enables.
    op(1'b1, 3'd5, 4'hF, 32'h11223344, 1'b0, 3'd0);
    op(1'b1, 3'd5, 4'h5, 32'hFFFFFFFF, 1'b0, 3'd0);
    op(1'b0, 3'd0, 4'd0, 32'd0, 1'b1, 3'd5, 1, 32'h11FF33FF, 32'h11FF33FF);
    idle(3);

    // Single-pulse latency and hold.
    op(1'b1, 3'd2, 4'hF, 32'hDEADBEEF, 1'b0, 3'd0);
    op(1'b0, 3'd0, 4'd0, 32'd0, 1'b1, 3'd2, 1, 32'hDEADBEEF, 32'hDEADBEEF);
    idle(5);

    // Same-edge collision on addr 3.
    op(1'b1, 3'd3, 4'hF, 32'h00000000, 1'b0, 3'd0);
    op(1'b1, 3'd3, 4'hF, 32'h12345678, 1'b1, 3'd3, 1, 32'h00000000, 32'h12345678);
    op(1'b0, 3'd0, 4'd0, 32'd0, 1'b1, 3'd3, 1, 32'h12345678, 32'h12345678);
    idle(3);

    // Randomised traffic with frequent same-address collisions.
    for (int i = 0; i < 300; i++) begin
      logic [2:0] wa, ra;
      wa = 3'($urandom_range(0, 7));
      ra = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom_range(0, 7));
      op(1'($urandom_range(0, 1)), wa, 4'($urandom), $urandom,
         1'($urandom_range(0, 3) != 0), ra);
    end
    idle(3);

    // Reset with a read in flight: nothing stale may emerge afterwards.
    op(1'b0, 3'd0, 4'd0, 32'd0, 1'b1, 3'd1);
    reset_and_sweep(0);
    idle(4);

    // Reset in the middle of a sweep, then verify a full clean sweep.
    reset_and_sweep(4);
    for (int a = 0; a < 8; a++) op(1'b0, 3'd0, 4'd0, 32'd0, 1'b1, 3'(a), 1, IV, IV);
    idle(4);

    for (int d = 0; d < 2; d++) chk("drain_queue", d, exp_q[d].size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ram_sync_read_sdp.md
# ram_sync_read_sdp

Parameterised simple-dual-port synchronous-read RAM: one write port with byte enables, one independent read port with read enable, selectable 1- or 2-cycle read latency, a defined read/write collision policy and an optional post-reset clear sweep. Used as the general data/coefficient store in the datapath wherever the single-port synchronous-read RAM lacks concurrent read/write, partial writes or a known initial state.

## Interface
- AWIDTH, 3 - address width; DEPTH = 2**AWIDTH
- DWIDTH, 32 - data width; must be a multiple of 8; NBYTES = DWIDTH/8
- OUT_REG, 0 - 0: read latency 1; 1: extra output register, latency 2
- RW_MODE, 0 - same-address collision: 0 read-first (old data), 1 write-first (new data)
- INIT_ON_RESET, 1 - 1: clear sweep after reset; 0: no sweep, contents undefined
- INIT_VALUE, 0 - DWIDTH-bit word written to every entry by the sweep

- clock  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-high
- wr_en  in  1  write strobe
- wr_addr  in  AWIDTH  write address
- wr_be  in  NBYTES  byte enables; bit i covers wr_data[8i+7:8i]
- wr_data  in  DWIDTH  write data
- rd_en  in  1  read strobe
- rd_addr  in  AWIDTH  read address
- rd_data  out  DWIDTH  read data
- rd_valid  out  1  one-cycle pulse, rd_data holds the requested word
- init_busy  out  1  clear sweep in progress; ports ignored

## Operation
- Reset (asserted): rd_data = 0, rd_valid = 0, pipeline stage cleared, sweep counter = 0, init_busy = INIT_ON_RESET. Array contents not touched by reset itself.
- FSM states: INIT, RUN. Reset enters INIT if INIT_ON_RESET=1, else RUN.
- INIT: each cycle writes INIT_VALUE (all bytes) to address cnt, cnt increments; after writing DEPTH-1 go to RUN. wr_en and rd_en ignored, rd_valid held 0, rd_data held 0.
- RUN write: on edge with wr_en=1, byte i of mem[wr_addr] updated iff wr_be[i]=1; wr_be=0 is a no-op.
- RUN read: on edge with rd_en=1, mem[rd_addr] captured; presented after latency; rd_valid pulses with it. With rd_en=0, rd_data holds its last value, rd_valid = 0.
- Collision (wr_en & rd_en, wr_addr = rd_addr, same edge): RW_MODE=0 returns pre-write word; RW_MODE=1 returns merged word (enabled bytes from wr_data, others old). Different addresses: fully independent.
- Read of an address written on an earlier edge always returns the written data regardless of RW_MODE.
- Out-of-range addresses impossible (DEPTH = 2**AWIDTH).

## Timing
- Read latency: rd_en sampled at edge N -> rd_data/rd_valid updated at edge N+1 (OUT_REG=0) or N+2 (OUT_REG=1). Back-to-back reads every cycle, full throughput.
- Write visible to reads issued at edge N+1 onward (edge N for RW_MODE=1 same-address).
- Sweep: reset deasserted before edge 0; writes at edges 0..DEPTH-1; init_busy falls after edge DEPTH-1; first accepted access at edge DEPTH.
- Reset mid-sweep or mid-read: sweep restarts from address 0; in-flight reads discarded (no rd_valid emerges).
- OUT_REG=1 in INIT: second stage also held 0.

## Test plan
- Sweep: AWIDTH=3, INIT_VALUE=32'hA5A5A5A5 -> init_busy high exactly 8 cycles after reset release; reads of addresses 0..7 all return A5A5A5A5.
- Byte enables: write 32'h11223344 to addr 5 be=4'b1111, then 32'hFFFFFFFF be=4'b0101 -> read addr 5 returns 32'h11FF33FF.
- Latency: OUT_REG=0 and 1, rd_en pulse on addr 2 holding 32'hDEADBEEF -> rd_valid and data exactly 1 / 2 edges later; rd_data stable while rd_en=0.
- Collision: addr 3 = 32'h0, same-edge write 32'h12345678 be=4'hF and read addr 3 -> RW_MODE=0 returns 0, RW_MODE=1 returns 12345678; next read returns 12345678 both modes.
- Ignore during sweep: wr_en=1 addr 0 data 32'hCAFEF00D during init_busy -> addr 0 reads INIT_VALUE, rd_valid never pulses during sweep.
- Reset mid-operation: assert reset at sweep cycle 4 and with a read in flight -> rd_valid/rd_data 0 immediately, sweep rerun for full 8 cycles, no stale rd_valid.
